// File: rtl/mem_arbiter_if.sv
// Request/response port of the memory arbiter: one instance each for the core and debug/DMA requesters.
// Address width follows `DATA_BITS (word address = `DATA_BITS-2).
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

interface mem_arbiter_if;
  localparam int AW = `DATA_BITS - 2;

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_wren;
  logic [3:0]    req_byteena;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;

  modport slave (
    input  req_valid, req_addr, req_wren, req_byteena, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

  modport master (
    output req_valid, req_addr, req_wren, req_byteena, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (core, debug/DMA) arbiter onto a single-cycle data memory with 1-cycle responses.
// Define ARBITER_ROUND_ROBIN_EN for round-robin on contention; default is fixed core priority.
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

module mem_arbiter (
  input  logic                   clock,
  input  logic                   reset_n,
  mem_arbiter_if.slave           c_port,
  mem_arbiter_if.slave           d_port,
  output logic [`DATA_BITS-3:0]  mem_address,
  output logic [3:0]             mem_byteena,
  output logic [31:0]            mem_data,
  output logic                   mem_wren,
  input  logic [31:0]            mem_q
);
  localparam int AW = `DATA_BITS - 2;

  logic          gnt_c, gnt_d, any_gnt;
  logic          last_grant_q;
  logic          rsp_pend_q;
  logic          rsp_port_q;
  logic [31:0]   rdata_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;

  // Grant decision; reset_n gating keeps every ready low while in reset.
  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    if (reset_n) begin
      if (c_port.req_valid && d_port.req_valid) begin
`ifdef ARBITER_ROUND_ROBIN_EN
        gnt_c = last_grant_q;
        gnt_d = !last_grant_q;
`else
        gnt_c = 1'b1;
`endif
      end else begin
        gnt_c = c_port.req_valid;
        gnt_d = d_port.req_valid;
      end
    end
  end

  assign any_gnt          = gnt_c | gnt_d;
  assign c_port.req_ready = gnt_c;
  assign d_port.req_ready = gnt_d;

  // Memory bus mux; idle cycles replay the last driven address/data with writes off.
  always_comb begin
    mem_address = addr_q;
    mem_byteena = be_q;
    mem_data    = wdata_q;
    mem_wren    = 1'b0;
    if (gnt_c) begin
      mem_address = c_port.req_addr;
      mem_byteena = c_port.req_byteena;
      mem_data    = c_port.req_wdata;
      mem_wren    = c_port.req_wren;
    end else if (gnt_d) begin
      mem_address = d_port.req_addr;
      mem_byteena = d_port.req_byteena;
      mem_data    = d_port.req_wdata;
      mem_wren    = d_port.req_wren;
    end
  end

  always_ff @(posedge clock) begin
    if (any_gnt) begin
      addr_q  <= mem_address;
      be_q    <= mem_byteena;
      wdata_q <= mem_data;
    end
  end

  // Response stage: mem_q is captured at the accepting edge, so writes return the pre-write word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      rsp_pend_q   <= 1'b0;
      rsp_port_q   <= 1'b0;
      rdata_q      <= 32'h0;
    end else begin
      rsp_pend_q <= any_gnt;
      if (any_gnt) begin
        rsp_port_q   <= gnt_d;
        last_grant_q <= gnt_d;
        rdata_q      <= mem_q;
      end
    end
  end

  assign c_port.rsp_valid = rsp_pend_q & !rsp_port_q;
  assign d_port.rsp_valid = rsp_pend_q &  rsp_port_q;
  assign c_port.rsp_rdata = rdata_q;
  assign d_port.rsp_rdata = rdata_q;

endmodule
